// File: rtl/ring_mon_pkg.sv
// Shared types and constants for the one-hot ring sequence monitor.
// Imported by the event FIFO and the monitor top level.
package ring_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        FAULT
    } state_e;

    typedef enum logic [1:0] {
        E_NONE,
        E_ILLEGAL,
        E_SKIP,
        E_STALL
    } err_code_e;

    typedef enum logic {
        EVT_LAP,
        EVT_ERR
    } evt_type_e;

    localparam int EVT_PAYLOAD_W = 8;

    typedef struct packed {
        evt_type_e                typ;
        logic [EVT_PAYLOAD_W-1:0] payload;
    } evt_t;

    localparam logic [3:0] OH_0 = 4'b0001;
    localparam logic [3:0] OH_1 = 4'b0010;
    localparam logic [3:0] OH_2 = 4'b0100;
    localparam logic [3:0] OH_3 = 4'b1000;

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        unique case (1'b1)
            v[1]:    r = 2'd1;
            v[2]:    r = 2'd2;
            v[3]:    r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ring_seq_monitor_if.sv
// Valid/ready event stream from the ring monitor to its consumer.
// The monitor drives the master side, software-facing logic the slave.
interface ring_seq_monitor_if #(
    parameter int LAP_W = 8
);
    logic             evt_valid;
    logic             evt_ready;
    logic             evt_type;
    logic [LAP_W-1:0] evt_payload;

    modport master (
        output evt_valid,
        output evt_type,
        output evt_payload,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_type,
        input  evt_payload,
        output evt_ready
    );
endinterface

// File: rtl/ring_evt_fifo.sv
// Small first-word-fall-through FIFO for monitor events.
// Accepts a push when full only if a pop happens in the same cycle.
module ring_evt_fifo
    import ring_mon_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = evt_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T           mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        push_ok;
    logic        pop_ok;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + (AW+1)'(1);
        if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ring_seq_monitor.sv
// Watches a 4-bit one-hot ring counter: index, lap count, error
// detection, and a valid/ready event queue for lap and error reports.
module ring_seq_monitor
    import ring_mon_pkg::*;
#(
    parameter int BITS_COUNT = 4,
    parameter int LAP_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BITS_COUNT-1:0] count_in,
    input  logic                  load_in,
    input  logic                  clear_err,
    output logic [1:0]            idx,
    output logic                  idx_valid,
    output logic [LAP_W-1:0]      lap_count,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  evt_ovf,
    ring_seq_monitor_if.master    evt
);
    typedef struct packed {
        evt_type_e        typ;
        logic [LAP_W-1:0] payload;
    } evt_w_t;

    state_e                 state_q, state_d;
    logic [BITS_COUNT-1:0]  prev_q;
    logic                   load_d_q;
    logic [1:0]             idx_q, idx_d;
    logic [LAP_W-1:0]       lap_q, lap_d;
    logic                   err_q, err_d;
    err_code_e              code_q, code_d;
    logic                   ovf_q, ovf_d;

    logic                   is_zero, is_oh, is_ill;
    logic [BITS_COUNT-1:0]  exp_val;
    logic [1:0]             enc;
    logic                   fault;
    err_code_e              fcode;
    logic                   push, pop, full, empty;
    evt_w_t                 push_evt, head;

    assign is_zero = (count_in == '0);
    assign is_oh   = !is_zero &&
                     ((count_in & (count_in - 1'b1)) == '0);
    assign is_ill  = !is_zero && !is_oh;
    assign exp_val = {prev_q[BITS_COUNT-2:0], prev_q[BITS_COUNT-1]};
    assign enc     = onehot_idx(count_in);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lap_d    = lap_q;
        err_d    = err_q;
        code_d   = code_q;
        ovf_d    = ovf_q;
        fault    = 1'b0;
        fcode    = E_NONE;
        push     = 1'b0;
        push_evt = '0;

        if (clear_err) begin
            ovf_d  = 1'b0;
            err_d  = 1'b0;
            code_d = E_NONE;
            if (state_q == FAULT) state_d = IDLE;
        end

        unique case (state_q)
            IDLE: begin
                if (is_oh) begin
                    state_d = TRACK;
                    idx_d   = enc;
                end else if (is_ill) begin
                    fault = 1'b1;
                    fcode = E_ILLEGAL;
                end
            end
            TRACK: begin
                if (is_zero) begin
                    state_d = IDLE;
                end else if (is_ill) begin
                    fault = 1'b1;
                    fcode = E_ILLEGAL;
                end else if (load_d_q || count_in == exp_val) begin
                    idx_d = enc;
                    // A resync sample never counts as a lap.
                    if (!load_d_q && prev_q == OH_3 && count_in == OH_0) begin
                        lap_d            = lap_q + LAP_W'(1);
                        push             = 1'b1;
                        push_evt.typ     = EVT_LAP;
                        push_evt.payload = lap_d;
                    end
                end else if (count_in == prev_q) begin
                    fault = 1'b1;
                    fcode = E_STALL;
                end else begin
                    fault = 1'b1;
                    fcode = E_SKIP;
                end
            end
            FAULT: ;
            default: state_d = IDLE;
        endcase

        if (fault) begin
            state_d = FAULT;
            err_d   = 1'b1;
            if (code_q == E_NONE) code_d = fcode;
            push             = 1'b1;
            push_evt.typ     = EVT_ERR;
            push_evt.payload = LAP_W'(code_d);
        end

        if (push && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            prev_q   <= '0;
            load_d_q <= 1'b0;
            idx_q    <= '0;
            lap_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= E_NONE;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= count_in;
            load_d_q <= load_in;
            idx_q    <= idx_d;
            lap_q    <= lap_d;
            err_q    <= err_d;
            code_q   <= code_d;
            ovf_q    <= ovf_d;
        end
    end

    assign pop = !empty && evt.evt_ready;

    ring_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_w_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_evt),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign idx             = idx_q;
    assign idx_valid       = (state_q == TRACK);
    assign lap_count       = lap_q;
    assign err             = err_q;
    assign err_code        = code_q;
    assign evt_ovf         = ovf_q;
    assign evt.evt_valid   = !empty;
    assign evt.evt_type    = head.typ;
    assign evt.evt_payload = head.payload;

endmodule

// File: doc/ring_seq_monitor.md
Name: ring_seq_monitor

Overview:
- Downstream consumer of the 4-bit one-hot ring counter (sequence 1->2->4->8->1, with synchronous reset and parallel load).
- Samples the counter's count and load outputs every clock, then:
  - encodes the one-hot position to a binary index;
  - counts completed laps;
  - detects illegal values, skipped steps and stalls.
- Reports lap and error events to a software-visible consumer through a small valid/ready event FIFO.

Parameters:
- BITS_COUNT, 4, width of monitored count; only the value 4 is supported.
- LAP_W, 8, lap counter width; also the event payload width.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- count_in  in  BITS_COUNT  upstream counter value.
- load_in  in  1  upstream load strobe, same cycle as its data_in.
- clear_err  in  1  one-cycle pulse; clears err, err_code and evt_ovf, and leaves FAULT.
- idx  out  2  binary position of the last accepted one-hot sample (1->0, 2->1, 4->2, 8->3).
- idx_valid  out  1  high while in TRACK.
- lap_count  out  LAP_W  number of completed 8->1 wraps.
- err  out  1  sticky error flag.
- err_code  out  2  first error: 00 none, 01 ILLEGAL, 10 SKIP, 11 STALL.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head entry when evt_valid && evt_ready.
- evt_type  out  1  0 = LAP, 1 = ERR.
- evt_payload  out  LAP_W  LAP: lap_count after increment; ERR: err_code zero-extended.
- evt_ovf  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset values: every output is 0; state is IDLE; prev = 0; load_d = 0; FIFO is empty.
- Internal registers: prev (last sample) and load_d (load_in delayed one cycle).
- Sample classes for count_in:
  - ZERO: value 0.
  - ONEHOT: exactly one bit set.
  - ILLEGAL: any other value.
- Expected successor exp = rotate-left-by-1 of prev (8 -> 1).
- Timing: classification is combinational on count_in and prev. All updates (state, idx, lap_count, err, FIFO push) take effect at the same rising edge. Event-to-evt_valid latency is 0 cycles after that edge (first-word fall-through).
- IDLE:
  - ZERO -> stay in IDLE.
  - ONEHOT -> TRACK; idx updated; no lap increment.
  - ILLEGAL -> FAULT with code 01.
- TRACK, when load_d = 1 (resync):
  - ONEHOT -> accepted without a sequence check; no lap increment.
  - ZERO -> IDLE.
  - ILLEGAL -> FAULT with code 01.
- TRACK, when load_d = 0:
  - count_in == exp -> stay in TRACK; update idx. If prev == 8 and count_in == 1, lap_count increments and a LAP event is pushed.
  - ZERO -> IDLE (upstream reset); lap_count is held.
  - ILLEGAL -> FAULT with code 01.
  - ONEHOT and count_in == prev -> FAULT with code 11.
  - Any other ONEHOT value -> FAULT with code 10.
- Entering FAULT:
  - err is set; err_code is latched only if it is currently 00 (the first error wins).
  - One ERR event is pushed.
  - idx and lap_count hold their values.
- FAULT:
  - Samples are ignored; no further events are generated.
  - clear_err -> IDLE at the next edge; err, err_code and evt_ovf are cleared.
  - clear_err in any other state clears only evt_ovf and err_code/err (both already 0 outside FAULT).
- lap_count wraps from 2^LAP_W-1 to 0; the LAP event at the wrap carries payload 0.
- FIFO rules:
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the push is dropped and evt_ovf is set.
  - Pop and push in the same cycle are allowed at any occupancy.
  - evt_type and evt_payload are don't-care while evt_valid = 0.
- Reset asserted mid-operation clears everything immediately, including FIFO contents and sticky flags.
- prev and load_d update every cycle in every state.

Decomposition:
- Package ring_mon_pkg:
  - state enum {IDLE, TRACK, FAULT};
  - err_code enum {E_NONE, E_ILLEGAL, E_SKIP, E_STALL};
  - evt_type enum {EVT_LAP, EVT_ERR};
  - event struct {type, payload};
  - one-hot constants 1/2/4/8.
- Sub-module ring_evt_fifo:
  - parameterised synchronous FIFO (depth, element = event struct);
  - push/pop/full/empty ports, fall-through read.
- Top level holds the classifier, FSM, lap counter and sticky flags.

Test Plan:
- Reset, then drive 0 and then 1,2,4,8,1,2 -> idx sequence 0,1,2,3,0,1; lap_count = 1 after the 8->1 step; exactly one LAP event with payload 1.
- In TRACK at 2, drive 8 -> FAULT; err = 1; err_code = 10; ERR event payload 2. Later drive 3 -> err_code stays 10 and no new event. Pulse clear_err -> IDLE with err = 0.
- In TRACK at 4, pulse load_in with count_in = 4, then drive 1 on the next cycle -> no error; idx = 0; no lap increment. Then 2 -> TRACK continues normally.
- Hold evt_ready = 0 through 6 laps -> 4 events queued; evt_ovf = 1. Then raise evt_ready -> payloads 1,2,3,4 drain in order; evt_valid = 0 afterwards.
- Set LAP_W = 2 and run 4 laps -> lap_count goes 1,2,3,0; the fourth event has payload 0.
- Assert reset asynchronously mid-lap with 3 events queued -> all outputs 0 immediately, before the next edge; FIFO empty. After release, drive 4,1 -> IDLE->TRACK on the 4, then SKIP error on the 1.
